// File: rtl/muladd_inv_if.sv
// muladd_inv_if: operand/result handshake bundle for the multiply-add inverse
interface muladd_inv_if #(
    parameter int DWIDTH1 = 16,
    parameter int DWIDTH2 = 16,
    parameter int DWIDTH  = 32
);
    logic               in_valid;
    logic               in_ready;
    logic [DWIDTH-1:0]  p;
    logic [DWIDTH-1:0]  c;
    logic               subtract;
    logic [DWIDTH2-1:0] b;
    logic               out_valid;
    logic               out_ready;
    logic [DWIDTH1-1:0] a;
    logic [DWIDTH-1:0]  r;
    logic               ovf;
    logic               dz;
    modport master (
        output in_valid, p, c, subtract, b, out_ready,
        input  in_ready, out_valid, a, r, ovf, dz
    );
    modport slave (
        input  in_valid, p, c, subtract, b, out_ready,
        output in_ready, out_valid, a, r, ovf, dz
    );
endinterface

// File: rtl/muladd_inv.sv
// muladd_inv: recovers a from p = a*b +/- c via iterative signed restoring division
module muladd_inv #(
    parameter int DWIDTH1 = 16,
    parameter int DWIDTH2 = 16,
    parameter int DWIDTH  = 32
) (
    input logic clk,
    input logic Reset,
    muladd_inv_if.slave io
);
    localparam int CW = $clog2(DWIDTH);
    typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;
    state_t state, state_nx;
    logic [DWIDTH-1:0]  p_r, c_r, div_r, dvd, dividend, q_s, rem_ext, r_s, lim;
    logic [DWIDTH2-1:0] b_r, mag_b;
    logic [DWIDTH2:0]   rem, rem_sh, diff;
    logic [CW-1:0]      cnt;
    logic               sub_r, sd, sb, dz_r, ge, q_neg, ovf_w;
    assign io.in_ready = (state == IDLE) && !Reset;
    // operand arithmetic: dividend, one shift-subtract step, and sign/overflow fix-up
    always_comb begin
        dividend = sub_r ? p_r + c_r : p_r - c_r;
        rem_sh   = {rem[DWIDTH2-1:0], dvd[DWIDTH-1]};
        diff     = rem_sh - {1'b0, mag_b};
        ge       = rem_sh >= {1'b0, mag_b};
        q_neg    = sd ^ sb;
        q_s      = q_neg ? -dvd : dvd;
        rem_ext  = {{(DWIDTH-DWIDTH2-1){1'b0}}, rem};
        r_s      = sd ? -rem_ext : rem_ext;
        lim      = DWIDTH'(1) << (DWIDTH1 - 1);
        ovf_w    = q_neg ? (dvd > lim) : (dvd >= lim);
    end
    // state register
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) state <= IDLE;
        else       state <= state_nx;
    end
    // next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = io.in_valid ? PREP : IDLE;
            PREP:    state_nx = ITER;
            ITER:    state_nx = (cnt == CW'(DWIDTH - 1)) ? FIX : ITER;
            FIX:     state_nx = DONE;
            DONE:    state_nx = io.out_ready ? IDLE : DONE;
            default: state_nx = IDLE;
        endcase
    end
    // datapath: capture operands, run the divider, publish and hold the result
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            {p_r, c_r, div_r, dvd, b_r, mag_b, rem, cnt, sub_r, sd, sb, dz_r} <= '0;
            io.a         <= '0;
            io.r         <= '0;
            io.ovf       <= 1'b0;
            io.dz        <= 1'b0;
            io.out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: if (io.in_valid) begin
                    p_r   <= io.p;
                    c_r   <= io.c;
                    sub_r <= io.subtract;
                    b_r   <= io.b;
                end
                PREP: begin
                    div_r <= dividend;
                    dvd   <= dividend[DWIDTH-1] ? -dividend : dividend;
                    mag_b <= b_r[DWIDTH2-1] ? -b_r : b_r;
                    sd    <= dividend[DWIDTH-1];
                    sb    <= b_r[DWIDTH2-1];
                    dz_r  <= b_r == '0;
                    rem   <= '0;
                    cnt   <= '0;
                end
                ITER: begin
                    rem <= ge ? diff : rem_sh;
                    dvd <= {dvd[DWIDTH-2:0], ge};
                    cnt <= cnt + 1'b1;
                end
                FIX: begin
                    io.a         <= dz_r ? '1 : q_s[DWIDTH1-1:0];
                    io.r         <= dz_r ? div_r : r_s;
                    io.ovf       <= !dz_r && ovf_w;
                    io.dz        <= dz_r;
                    io.out_valid <= 1'b1;
                end
                DONE: if (io.out_ready) io.out_valid <= 1'b0;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_muladd_inv.sv
// tb_muladd_inv: directed vector bench for the multiply-add inverse
module tb_muladd_inv;
    typedef struct {
        logic [31:0] p;
        logic [31:0] c;
        logic        sub;
        logic [15:0] b;
        logic [15:0] a;
        logic [31:0] r;
        logic        ovf;
        logic        dz;
    } vec_t;
    logic clk = 1'b0;
    logic Reset = 1'b1;
    int   errors = 0;
    int   checks = 0;
    vec_t v[10];
    muladd_inv_if #(.DWIDTH1(16), .DWIDTH2(16), .DWIDTH(32)) io ();
    muladd_inv #(.DWIDTH1(16), .DWIDTH2(16), .DWIDTH(32)) dut (
        .clk(clk),
        .Reset(Reset),
        .io(io.slave)
    );
    always #5 clk = ~clk;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask
    // accept a vector, measure latency counting the accept edge as edge 1, check the result
    task automatic issue(input vec_t t, input string nm);
        int lat;
        @(negedge clk);
        io.p = t.p;
        io.c = t.c;
        io.subtract = t.sub;
        io.b = t.b;
        io.in_valid = 1'b1;
        chk({nm, " in_ready"}, 32'(io.in_ready), 32'd1);
        @(posedge clk);
        #1;
        io.in_valid = 1'b0;
        io.p = 32'hDEADBEEF;
        io.c = 32'h12345678;
        io.subtract = ~t.sub;
        io.b = 16'h0000;
        lat = 1;
        while (!io.out_valid && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({nm, " latency"}, 32'(lat), 32'd35);
        chk({nm, " a"}, 32'(io.a), 32'(t.a));
        chk({nm, " r"}, io.r, t.r);
        chk({nm, " ovf"}, 32'(io.ovf), 32'(t.ovf));
        chk({nm, " dz"}, 32'(io.dz), 32'(t.dz));
    endtask
    task automatic handshake(input string nm);
        @(negedge clk);
        io.out_ready = 1'b1;
        @(posedge clk);
        #1;
        io.out_ready = 1'b0;
        chk({nm, " out_valid drop"}, 32'(io.out_valid), 32'd0);
        chk({nm, " in_ready back"}, 32'(io.in_ready), 32'd1);
    endtask
    initial begin
        int seen;
        v[0] = '{32'd100, 32'd7, 1'b0, 16'd3, 16'h001F, 32'd0, 1'b0, 1'b0};
        v[1] = '{32'hFFFFFFCE, 32'd0, 1'b1, 16'd7, 16'hFFF9, 32'hFFFFFFFF, 1'b0, 1'b0};
        v[2] = '{32'hFFFFEE49, 32'd1000, 1'b0, 16'd45, 16'hFF85, 32'd0, 1'b0, 1'b0};
        v[3] = '{32'd5, 32'd0, 1'b0, 16'd0, 16'hFFFF, 32'd5, 1'b0, 1'b1};
        v[4] = '{32'h80000000, 32'd0, 1'b0, 16'hFFFF, 16'h0000, 32'd0, 1'b1, 1'b0};
        v[5] = '{32'd70000, 32'd0, 1'b0, 16'd1, 16'h1170, 32'd0, 1'b1, 1'b0};
        v[6] = '{32'hFFFFFF9C, 32'd0, 1'b0, 16'hFFF9, 16'h000E, 32'hFFFFFFFE, 1'b0, 1'b0};
        v[7] = '{32'd10, 32'd5, 1'b1, 16'hFFFC, 16'hFFFD, 32'd3, 1'b0, 1'b0};
        v[8] = '{32'hFFFF8000, 32'd0, 1'b0, 16'd1, 16'h8000, 32'd0, 1'b0, 1'b0};
        v[9] = '{32'h00008000, 32'd0, 1'b0, 16'd1, 16'h8000, 32'd0, 1'b1, 1'b0};
        io.in_valid = 1'b0;
        io.out_ready = 1'b0;
        io.p = '0;
        io.c = '0;
        io.subtract = 1'b0;
        io.b = '0;
        #2;
        chk("reset in_ready", 32'(io.in_ready), 32'd0);
        chk("reset out_valid", 32'(io.out_valid), 32'd0);
        chk("reset a", 32'(io.a), 32'd0);
        chk("reset r", io.r, 32'd0);
        chk("reset flags", {30'd0, io.ovf, io.dz}, 32'd0);
        @(negedge clk);
        Reset = 1'b0;
        #1;
        chk("idle in_ready", 32'(io.in_ready), 32'd1);
        for (int i = 0; i < 10; i++) begin
            issue(v[i], $sformatf("vec%0d", i));
            handshake($sformatf("vec%0d", i));
        end
        issue(v[0], "bp");
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("bp hold valid %0d", i), 32'(io.out_valid), 32'd1);
            chk($sformatf("bp hold a %0d", i), 32'(io.a), 32'h001F);
            chk($sformatf("bp in_ready %0d", i), 32'(io.in_ready), 32'd0);
        end
        handshake("bp");
        @(negedge clk);
        io.p = 32'd100;
        io.c = 32'd7;
        io.subtract = 1'b0;
        io.b = 16'd3;
        io.in_valid = 1'b1;
        @(posedge clk);
        #1;
        io.in_valid = 1'b0;
        repeat (11) @(posedge clk);
        @(negedge clk);
        Reset = 1'b1;
        #1;
        chk("iter rst out_valid", 32'(io.out_valid), 32'd0);
        chk("iter rst in_ready", 32'(io.in_ready), 32'd0);
        @(negedge clk);
        Reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (io.out_valid) seen++;
        end
        chk("iter rst no result", 32'(seen), 32'd0);
        chk("iter rst idle", 32'(io.in_ready), 32'd1);
        issue(v[1], "post rst");
        @(negedge clk);
        Reset = 1'b1;
        #1;
        chk("done rst out_valid", 32'(io.out_valid), 32'd0);
        chk("done rst a", 32'(io.a), 32'd0);
        chk("done rst r", io.r, 32'd0);
        @(negedge clk);
        Reset = 1'b0;
        issue(v[2], "final");
        handshake("final");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
